// File: rtl/mem_stage.sv
// mem_stage: MEM-stage data memory unit. Accepts one load or store from
// EX/MEM, performs a multi-cycle word access to an internal data array, and
// holds stall_o high until the access is about to complete.
module mem_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] mdr_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        done_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_wr_q, is_wr_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            mis_q, mis_d;
  logic [31:0]     mdr_q, mdr_d;

  // Data array; deliberately not reset so contents survive rst_i.
  logic [31:0]     mem [DEPTH_WORDS];

  logic            req;
  logic            access_now;
  logic            unused_addr;

  assign req         = MemRead_i | MemWrite_i;
  assign access_now  = (state_q == BUSY) && (cnt_q == '0);
  // Upper address bits wrap into the array; low two bits only flag misalignment.
  assign unused_addr = ^addr_i[31:AW+2];

  // Next-state logic: capture the request in IDLE, count down in BUSY, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    mdr_d   = mdr_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          cnt_d   = CW'(LATENCY - 1);
          is_wr_d = MemWrite_i;          // write wins when both are requested
          idx_d   = addr_i[AW+1:2];
          wdata_d = wdata_i;
          mis_d   = |addr_i[1:0];
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!is_wr_q) begin
            mdr_d = mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        // Same instruction is still presented; the pipeline advances after this cycle.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and load-data registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      mdr_q   <= mdr_d;
    end
  end

  // Store commit on the last BUSY edge; a reset in flight drops the store.
  always_ff @(posedge clk_i) begin
    if (access_now && is_wr_q && !rst_i) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Outputs: stall covers the request cycle in IDLE plus every BUSY cycle.
  always_comb begin
    stall_o    = !rst_i && (((state_q == IDLE) && req) || (state_q == BUSY));
    done_o     = (state_q == DONE);
    misalign_o = (state_q == DONE) && mis_q;
    mdr_o      = mdr_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage against a
// word-array reference model.
module tb_mem_stage;

  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [31:0] mdr_o;
  logic        stall_o, misalign_o, done_o;

  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] mdr_m;

  mem_stage #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .MemRead_i  (mem_read),
    .MemWrite_i (mem_write),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .mdr_o      (mdr_o),
    .stall_o    (stall_o),
    .misalign_o (misalign_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One access: stall must last LAT+1 cycles, then a DONE cycle with the model's results.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold);
    int          stalls;
    int          idx;
    logic        mis;
    idx = int'((a >> 2) % DEPTH);
    mis = (a[1:0] != 2'b00);
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    #1;
    stalls = 0;
    while (stall_o === 1'b1 && stalls < 20) begin
      check("busy_done", {31'b0, done_o}, 32'd0);
      check("busy_mis", {31'b0, misalign_o}, 32'd0);
      check("busy_mdr", mdr_o, mdr_m);
      stalls++;
      @(negedge clk);
      addr  = $urandom;                 // must be ignored while busy
      wdata = $urandom;
      #1;
    end
    if (wr) mem_m[idx] = wd;
    else    mdr_m = mem_m[idx];
    check("stall_cycles", stalls, LAT + 1);
    check("done", {31'b0, done_o}, 32'd1);
    check("misalign", {31'b0, misalign_o}, {31'b0, mis});
    check("mdr", mdr_o, mdr_m);
    $display("access rd=%0b wr=%0b addr=%h wdata=%h -> mdr=%h mis=%0b stalls=%0d",
             rd, wr, a, wd, mdr_o, misalign_o, stalls);
    if (!hold) begin
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      check("idle_stall", {31'b0, stall_o}, 32'd0);
      check("idle_done", {31'b0, done_o}, 32'd0);
      check("idle_mis", {31'b0, misalign_o}, 32'd0);
      check("idle_mdr", mdr_o, mdr_m);
    end
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    mdr_m = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", {31'b0, stall_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_mis", {31'b0, misalign_o}, 32'd0);
    check("rst_mdr", mdr_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed scenarios
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    access(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0);
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h413, 32'h0, 1'b0);

    // Fill the rest of the array so every later read has a known value
    for (int i = 0; i < DEPTH; i++) begin
      if (i != 4 && i != 8)
        access(1'b0, 1'b1, i * 4, $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset during the second BUSY cycle of a store
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b1; addr = 32'h40; wdata = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_stall", {31'b0, stall_o}, 32'd0);
    check("midrst_mdr", mdr_o, 32'd0);
    check("midrst_done", {31'b0, done_o}, 32'd0);
    mdr_m = '0;
    @(negedge clk);
    rst = 1'b0; mem_write = 1'b0;
    access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);

    // Back-to-back loads held through DONE
    access(1'b1, 1'b0, 32'h80, 32'h0, 1'b1);
    access(1'b1, 1'b0, 32'h84, 32'h0, 1'b0);

    // Randomized mix
    for (int i = 0; i < 300; i++) begin
      logic rd_r, wr_r;
      rd_r = 1'($urandom_range(0, 1));
      wr_r = 1'($urandom_range(0, 1));
      if (!rd_r && !wr_r) rd_r = 1'b1;
      access(rd_r, wr_r, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
